// File: rtl/pb_sequencer.sv
// pb_sequencer: plays a stored script of button codes onto the calculator pb bus as timed one-hot presses.
// Build option PB_SEQ_LOOP_EN adds a 'loop' input that repeats the script until it is dropped or aborted.
module pb_sequencer #(
  parameter int PB_W         = 20,
  parameter int DEPTH        = 16,
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   wr_en,
  input  logic [4:0]             wr_code,
  output logic                   wr_full,
  input  logic                   start,
  input  logic                   abort,
`ifdef PB_SEQ_LOOP_EN
  input  logic                   loop,
`endif
  output logic [PB_W-1:0]        pb,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int TMAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state_reg;
  logic [TW-1:0]   timer_reg;
  logic [AW-1:0]   rd_idx_reg;
  logic [LW-1:0]   level_reg;
  logic [PB_W-1:0] pb_reg;
  logic            busy_reg;
  logic            done_reg;

  logic [4:0]      mem [DEPTH];

  logic            wr_accept;
  logic            last_entry;
  logic            repeat_pass;
  logic [AW-1:0]   fetch_idx;
  logic [4:0]      fetch_code;
  logic [PB_W-1:0] fetch_onehot;

`ifdef PB_SEQ_LOOP_EN
  assign repeat_pass = loop;
`else
  assign repeat_pass = 1'b0;
`endif

  assign wr_full = (level_reg == LW'(DEPTH));

  // fetch_idx is the entry whose press starts on the next edge: entry 0 from IDLE
  // or on wrap-around, otherwise the one after the current entry.
  always_comb begin
    wr_accept  = (state_reg == IDLE) && wr_en && !wr_full && !start && !abort;
    last_entry = ({1'b0, rd_idx_reg} == (level_reg - 1'b1));
    fetch_idx  = '0;
    if (state_reg == GAP && !last_entry) begin
      fetch_idx = rd_idx_reg + 1'b1;
    end
    fetch_code = mem[fetch_idx];
  end

  // Codes >= PB_W match no bit, which is what makes them blank slots.
  for (genvar gi = 0; gi < PB_W; gi++) begin : g_decode
    assign fetch_onehot[gi] = (fetch_code == 5'(gi));
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[level_reg[AW-1:0]] <= wr_code;
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      rd_idx_reg <= '0;
      level_reg  <= '0;
      pb_reg     <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        state_reg  <= IDLE;
        timer_reg  <= '0;
        rd_idx_reg <= '0;
        level_reg  <= '0;
        pb_reg     <= '0;
        busy_reg   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              if (level_reg != '0) begin
                state_reg  <= PRESS;
                rd_idx_reg <= '0;
                timer_reg  <= TW'(PRESS_CYCLES - 1);
                pb_reg     <= fetch_onehot;
                busy_reg   <= 1'b1;
              end else begin
                done_reg <= 1'b1;
              end
            end else if (wr_accept) begin
              level_reg <= level_reg + 1'b1;
            end
          end
          PRESS: begin
            if (timer_reg == '0) begin
              state_reg <= GAP;
              timer_reg <= TW'(GAP_CYCLES - 1);
              pb_reg    <= '0;
            end else begin
              timer_reg <= timer_reg - 1'b1;
            end
          end
          GAP: begin
            if (timer_reg == '0) begin
              if (last_entry) begin
                done_reg   <= 1'b1;
                rd_idx_reg <= '0;
                if (repeat_pass) begin
                  state_reg <= PRESS;
                  timer_reg <= TW'(PRESS_CYCLES - 1);
                  pb_reg    <= fetch_onehot;
                end else begin
                  state_reg <= IDLE;
                  level_reg <= '0;
                  busy_reg  <= 1'b0;
                end
              end else begin
                state_reg  <= PRESS;
                rd_idx_reg <= rd_idx_reg + 1'b1;
                timer_reg  <= TW'(PRESS_CYCLES - 1);
                pb_reg     <= fetch_onehot;
              end
            end else begin
              timer_reg <= timer_reg - 1'b1;
            end
          end
          default: begin
            state_reg <= IDLE;
            pb_reg    <= '0;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pb    = pb_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign level = level_reg;

endmodule

// File: tb/tb_pb_sequencer.sv
// Self-checking bench for pb_sequencer: scripted and random scripts compared against a
// per-cycle timeline model derived from press/gap timing; covers loop mode when PB_SEQ_LOOP_EN is set.
module tb_pb_sequencer;

  localparam int PB_W    = 20;
  localparam int DEPTH   = 16;
  localparam int PRESS_C = 4;
  localparam int GAP_C   = 4;
  localparam int PERIOD  = PRESS_C + GAP_C;

  logic            clk = 1'b0;
  logic            nrst;
  logic            wr_en;
  logic [4:0]      wr_code;
  logic            wr_full;
  logic            start;
  logic            abort;
  logic            loop;
  logic [PB_W-1:0] pb;
  logic            busy;
  logic            done;
  logic [4:0]      level;

  int n_cmp = 0;
  int n_err = 0;
  int script_q[$];

  pb_sequencer #(
    .PB_W(PB_W), .DEPTH(DEPTH), .PRESS_CYCLES(PRESS_C), .GAP_CYCLES(GAP_C)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .wr_en(wr_en),
    .wr_code(wr_code),
    .wr_full(wr_full),
    .start(start),
    .abort(abort),
`ifdef PB_SEQ_LOOP_EN
    .loop(loop),
`endif
    .pb(pb),
    .busy(busy),
    .done(done),
    .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [PB_W-1:0] press_vec(input int code);
    logic [PB_W-1:0] one;
    one = '0;
    one[0] = 1'b1;
    if (code >= PB_W) return '0;
    return one << code;
  endfunction

  // {pb, busy, done} expected k cycles after the start edge for the script in script_q
  function automatic logic [PB_W+1:0] expect_at(input int k);
    int n, e, ph;
    n = script_q.size();
    if (k > n * PERIOD) return {{PB_W{1'b0}}, 1'b0, (k == n * PERIOD + 1)};
    e  = (k - 1) / PERIOD;
    ph = (k - 1) % PERIOD;
    return {((ph < PRESS_C) ? press_vec(script_q[e]) : {PB_W{1'b0}}), 1'b1, 1'b0};
  endfunction

  task automatic write_code(input int c);
    wr_en   = 1'b1;
    wr_code = 5'(c);
    @(negedge clk);
    wr_en = 1'b0;
    if (script_q.size() < DEPTH) script_q.push_back(c);
  endtask

  task automatic test_reset();
    nrst = 1'b1; wr_en = 1'b0; wr_code = '0; start = 1'b0; abort = 1'b0; loop = 1'b0;
    #12;
    n_cmp++;
    if ({pb, busy, done, level, wr_full} !== '0) begin
      n_err++;
      $display("FAIL reset: got pb=%h busy=%b done=%b level=%0d full=%b, want all 0",
               pb, busy, done, level, wr_full);
    end
    nrst = 1'b0;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_playback(input string name, input int n, input bit rand_codes);
    logic [PB_W+1:0] ex;
    int              c;
    for (int i = 0; i < n; i++) begin
      if (rand_codes) c = $urandom_range(0, 31);
      else c = script_q.size() == 0 ? 0 : 0;
      if (!rand_codes) c = (i == 0) ? 3 : (i == 1) ? 16 : 10;
      write_code(c);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    n_cmp++;
    if (level !== 5'(n) || wr_full !== (n == DEPTH)) begin
      n_err++;
      $display("FAIL %s level: got level=%0d full=%b, want level=%0d full=%b",
               name, level, wr_full, n, (n == DEPTH));
    end
    $display("playback %s: %0d entries", name, n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= n * PERIOD + 1; k++) begin
      ex = expect_at(k);
      n_cmp++;
      if ({pb, busy, done} !== ex) begin
        n_err++;
        $display("FAIL %s cycle %0d: got pb=%h busy=%b done=%b, want pb=%h busy=%b done=%b",
                 name, k, pb, busy, done, ex[PB_W+1:2], ex[1], ex[0]);
      end
      @(negedge clk);
    end
    script_q.delete();
    n_cmp++;
    if (level !== 5'd0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL %s end: got level=%0d done=%b, want level=0 done=0", name, level, done);
    end
  endtask

  task automatic test_blank();
    logic [PB_W+1:0] ex;
    write_code(25);
    write_code(2);
    $display("blank slot script {25,2}");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 2 * PERIOD + 1; k++) begin
      ex = expect_at(k);
      n_cmp++;
      if ({pb, busy, done} !== ex) begin
        n_err++;
        $display("FAIL blank cycle %0d: got pb=%h busy=%b done=%b, want pb=%h busy=%b done=%b",
                 k, pb, busy, done, ex[PB_W+1:2], ex[1], ex[0]);
      end
      @(negedge clk);
    end
    script_q.delete();
  endtask

  task automatic test_full();
    int cyc;
    for (int i = 0; i < 17; i++) begin
      write_code(i % PB_W);
      if (i == 15 || i == 16) begin
        n_cmp++;
        if (level !== 5'd16 || wr_full !== 1'b1) begin
          n_err++;
          $display("FAIL full write%0d: got level=%0d full=%b, want level=16 full=1",
                   i + 1, level, wr_full);
        end
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    $display("full script playback: done seen on cycle %0d", cyc);
    n_cmp++;
    if (cyc !== 16 * PERIOD + 1) begin
      n_err++;
      $display("FAIL full length: done on cycle %0d, want %0d", cyc, 16 * PERIOD + 1);
    end
    script_q.delete();
    @(negedge clk);
    n_cmp++;
    if (level !== 5'd0 || wr_full !== 1'b0) begin
      n_err++;
      $display("FAIL full clear: got level=%0d full=%b, want 0/0", level, wr_full);
    end
  endtask

  task automatic test_abort();
    int done_seen;
    write_code(7);
    write_code(1);
    write_code(12);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (pb !== press_vec(1) || busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort pre: got pb=%h busy=%b, want pb=%h busy=1", pb, busy, press_vec(1));
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    script_q.delete();
    $display("abort issued on 3rd cycle of 2nd press");
    n_cmp++;
    if ({pb, busy, done, level} !== '0) begin
      n_err++;
      $display("FAIL abort: got pb=%h busy=%b done=%b level=%0d, want all 0",
               pb, busy, done, level);
    end
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    n_cmp++;
    if (done_seen !== 0) begin
      n_err++;
      $display("FAIL abort done: got %0d done pulses, want 0", done_seen);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || pb !== '0) begin
      n_err++;
      $display("FAIL abort restart: got done=%b busy=%b pb=%h, want done=1 busy=0 pb=0",
               done, busy, pb);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int cyc;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || pb !== '0) begin
      n_err++;
      $display("FAIL empty start: got done=%b busy=%b pb=%h, want 1/0/0", done, busy, pb);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL empty start pulse: got done=%b on 2nd cycle, want 0", done);
    end
    start = 1'b1; wr_en = 1'b1; wr_code = 5'd9;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    $display("start+write with empty script");
    n_cmp++;
    if (level !== 5'd0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL start+wr empty: got level=%0d done=%b, want level=0 done=1", level, done);
    end
    c = $urandom_range(0, PB_W - 1);
    write_code(c);
    start = 1'b1; wr_en = 1'b1; wr_code = 5'd4;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    n_cmp++;
    if (level !== 5'd1 || busy !== 1'b1 || pb !== press_vec(c)) begin
      n_err++;
      $display("FAIL start+wr: got level=%0d busy=%b pb=%h, want level=1 busy=1 pb=%h",
               level, busy, pb, press_vec(c));
    end
    wr_en = 1'b1; wr_code = 5'd6;
    repeat (2) @(negedge clk);
    wr_en = 1'b0;
    n_cmp++;
    if (level !== 5'd1) begin
      n_err++;
      $display("FAIL write while busy: got level=%0d, want 1", level);
    end
    start = 1'b1;
    cyc = 0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    start = 1'b0;
    script_q.delete();
    n_cmp++;
    if (cyc !== PERIOD - 2) begin
      n_err++;
      $display("FAIL start while busy: done after %0d more cycles, want %0d", cyc, PERIOD - 2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    write_code(4);
    write_code(8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    nrst = 1'b1;
    #1;
    $display("async reset mid-playback");
    n_cmp++;
    if ({pb, busy, level} !== '0) begin
      n_err++;
      $display("FAIL reset mid: got pb=%h busy=%b level=%0d, want all 0", pb, busy, level);
    end
    @(negedge clk);
    nrst = 1'b0;
    script_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || pb !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset mid lost script: got done=%b pb=%h busy=%b, want 1/0/0",
               done, pb, busy);
    end
  endtask

`ifdef PB_SEQ_LOOP_EN
  task automatic test_loop();
    logic [PB_W+1:0] ex;
    loop = 1'b1;
    write_code(5);
    $display("loop script {5}");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 3 * PERIOD + 1; k++) begin
      if (k == 3 * PERIOD + 1)
        ex = {{PB_W{1'b0}}, 1'b0, 1'b1};
      else
        ex = {(((k - 1) % PERIOD) < PRESS_C) ? press_vec(5) : {PB_W{1'b0}}, 1'b1,
              (k > 1 && ((k - 1) % PERIOD) == 0)};
      n_cmp++;
      if ({pb, busy, done} !== ex) begin
        n_err++;
        $display("FAIL loop cycle %0d: got pb=%h busy=%b done=%b, want pb=%h busy=%b done=%b",
                 k, pb, busy, done, ex[PB_W+1:2], ex[1], ex[0]);
      end
      if (k == 20) loop = 1'b0;
      @(negedge clk);
    end
    script_q.delete();
    n_cmp++;
    if (level !== 5'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL loop end: got level=%0d busy=%b, want 0/0", level, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_playback("basic", 3, 1'b0);
    for (int it = 0; it < 6; it++) begin
      test_playback("random", $urandom_range(1, DEPTH), 1'b1);
    end
    test_full();
    test_blank();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef PB_SEQ_LOOP_EN
    test_loop();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
